// File: rtl/mem8_master.sv
// mem8_master: valid/ready request stream to sequenced SRAM-style bus cycles (addr/data/cs/oe/we).
module mem8_master #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] addr,
  inout  wire  [DW-1:0] data,
  output logic          cs,
  output logic          oe,
  output logic          we
);
  localparam int CW = $clog2((RD_CYCLES > WR_CYCLES ? RD_CYCLES : WR_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, SETUP, RD, WR, TURN} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] wdata;
  logic is_wr, drive, last_rd, last_wr, wr_next;
  assign req_ready = state == IDLE;
  assign last_rd = cnt == CW'(RD_CYCLES - 1);
  assign last_wr = cnt == CW'(WR_CYCLES - 1);
  assign wr_next = (state == IDLE) ? req_we : is_wr;
  assign data = drive ? wdata : 'z;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req_valid ? SETUP : IDLE;
      SETUP:   nxt = is_wr ? WR : RD;
      RD:      nxt = last_rd ? TURN : RD;
      WR:      nxt = last_wr ? TURN : WR;
      TURN:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Bus strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_wr     <= 1'b0;
      wdata     <= '0;
      addr      <= '0;
      cs        <= 1'b0;
      oe        <= 1'b0;
      we        <= 1'b0;
      drive     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= nxt;
      cnt   <= (state == RD || state == WR) ? cnt + 1'b1 : '0;
      if (state == IDLE && req_valid) begin
        is_wr <= req_we;
        addr  <= req_addr;
        wdata <= req_wdata;
      end
      cs        <= nxt != IDLE;
      oe        <= nxt == RD;
      we        <= nxt == WR;
      drive     <= wr_next && (nxt == SETUP || nxt == WR || nxt == TURN);
      rsp_valid <= nxt == TURN;
      if (state == RD && last_rd) rsp_rdata <= data;
    end
  end
endmodule

// File: tb/tb_mem8_master.sv
// tb_mem8_master: two masters (default and slow timing) each on its own registered-read RAM, checked against a memory model.
module tb_mem8_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  int sel = 0;
  logic [1:0] req_ready, rsp_valid, cs, oe, we;
  logic [7:0] rsp_rdata [2];
  logic [15:0] addr [2];
  wire [7:0] data0, data1;
  logic [7:0] ram0 [65536];
  logic [7:0] ram1 [65536];
  logic [7:0] rq0, rq1;
  logic [7:0] exp_mem [2][65536];
  bit known [2][65536];
  logic [7:0] last_rd [2];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mem8_master u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel == 0), .req_ready(req_ready[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .addr(addr[0]), .data(data0), .cs(cs[0]), .oe(oe[0]), .we(we[0])
  );
  mem8_master #(.RD_CYCLES(4), .WR_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel == 1), .req_ready(req_ready[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .addr(addr[1]), .data(data1), .cs(cs[1]), .oe(oe[1]), .we(we[1])
  );
  always @(posedge clk) begin
    if (cs[0] && we[0]) ram0[addr[0]] <= data0;
    if (cs[1] && we[1]) ram1[addr[1]] <= data1;
    rq0 <= ram0[addr[0]];
    rq1 <= ram1[addr[1]];
  end
  assign data0 = (cs[0] && oe[0]) ? rq0 : 'z;
  assign data1 = (cs[1] && oe[1]) ? rq1 : 'z;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    check("oe_we_a", oe[0] & we[0], 0);
    check("oe_we_b", oe[1] & we[1], 0);
  end
  // Called at a negedge; returns at the negedge of the IDLE cycle after the response.
  task automatic txn(input int s, input logic w, input logic [15:0] a, input logic [7:0] d, input bit hold);
    int n, lat;
    logic [7:0] bus;
    bit strobe;
    sel = s; req_we = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    while (!req_ready[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept", req_ready[s], 1);
    @(posedge clk);
    lat = w ? (s == 1 ? 3 : 1) + 2 : (s == 1 ? 4 : 2) + 2;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) req_valid = 1'b0;
      bus = s == 1 ? data1 : data0;
      strobe = k >= 2 && k < lat;
      check("cs", cs[s], 1);
      check("oe", oe[s], !w && strobe);
      check("we", we[s], w && strobe);
      check("rsp_valid", rsp_valid[s], k == lat);
      check("busy", req_ready[s], 0);
      check("addr", addr[s], a);
      if (w && strobe) check("wbus", bus, d);
      if (!w && strobe && known[s][a]) check("rbus", bus, exp_mem[s][a]);
      if (k == lat && w) check("rdata_hold", rsp_rdata[s], last_rd[s]);
      if (k == lat && !w && known[s][a]) check("rdata", rsp_rdata[s], exp_mem[s][a]);
    end
    if (w) begin
      exp_mem[s][a] = d;
      known[s][a] = 1'b1;
    end else if (known[s][a]) last_rd[s] = exp_mem[s][a];
    else last_rd[s] = rsp_rdata[s];
    @(negedge clk);
    check("gap_cs", cs[s], 0);
    check("gap_ready", req_ready[s], 1);
    check("gap_rsp", rsp_valid[s], 0);
  endtask
  initial begin
    logic [15:0] ra;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_cs", cs[i], 0);
      check("rst_oe", oe[i], 0);
      check("rst_we", we[i], 0);
      check("rst_rsp", rsp_valid[i], 0);
      check("rst_rdata", rsp_rdata[i], 0);
      check("rst_addr", addr[i], 0);
      check("rst_ready", req_ready[i], 1);
    end
    rst = 1'b0;
    @(negedge clk);
    txn(0, 1'b1, 16'h1234, 8'hA5, 1'b0);
    txn(0, 1'b0, 16'h1234, 8'h00, 1'b0);
    check("t1_rdata", rsp_rdata[0], 8'hA5);
    for (int i = 0; i < 16; i++) txn(0, 1'b1, 16'(i), 8'(i), 1'b1);
    for (int i = 0; i < 16; i++) txn(0, 1'b0, 16'(i), 8'h00, i < 15);
    txn(0, 1'b1, 16'hFFFF, 8'h5A, 1'b0);
    txn(0, 1'b1, 16'h0000, 8'h3C, 1'b0);
    txn(0, 1'b0, 16'hFFFF, 8'h00, 1'b0);
    check("t3_ffff", rsp_rdata[0], 8'h5A);
    txn(0, 1'b0, 16'h0000, 8'h00, 1'b0);
    check("t3_0000", rsp_rdata[0], 8'h3C);
    txn(0, 1'b1, 16'h0011, 8'hC3, 1'b0);
    sel = 0; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 8'h77; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("t4_setup_we", we[0], 0);
    @(negedge clk);
    check("t4_wr_we", we[0], 1);
    rst = 1'b1;
    @(negedge clk);
    check("t4_cs", cs[0], 0);
    check("t4_oe", oe[0], 0);
    check("t4_we", we[0], 0);
    check("t4_rsp", rsp_valid[0], 0);
    check("t4_ready", req_ready[0], 1);
    rst = 1'b0;
    known[0][16'h0010] = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    check("t4_idle_rsp", rsp_valid[0], 0);
    txn(0, 1'b0, 16'h0011, 8'h00, 1'b0);
    check("t4_read", rsp_rdata[0], 8'hC3);
    txn(1, 1'b1, 16'hBEEF, 8'h96, 1'b0);
    txn(1, 1'b1, 16'h0000, 8'h69, 1'b0);
    txn(1, 1'b0, 16'hBEEF, 8'h00, 1'b0);
    check("t5_rdata", rsp_rdata[1], 8'h96);
    txn(1, 1'b0, 16'h0000, 8'h00, 1'b1);
    for (int i = 0; i < 80; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), ra, 8'($urandom), i < 79 && $urandom_range(0, 1) == 1);
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
